fabric_frame_loader: RTL
========================

FABRIC_FRAME_LOADER -- requirements
Module: fabric_frame_loader

Interface
REQ-001 Parameter FrameBitsPerRow, default 32: frame bits per fabric row; SHALL be a multiple of 32.
REQ-002 Parameter MaxFramesPerCol, default 20: frame strobes per column.
REQ-003 Parameter NumColumns, default 9: fabric columns.
REQ-004 Parameter NumRows, default 14: fabric rows.
REQ-005 Parameter DATA_W, default 32: bitstream input width; legal values 8, 16, 32.
REQ-006 clk_i  input  1  sole clock, rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 bitstream_data_i  input  DATA_W  bitstream beat.
REQ-009 bitstream_valid_i  input  1  beat valid.
REQ-010 bitstream_ready_o  output  1  beat accepted when valid and ready are both high.
REQ-011 busy_o  output  1  configuration in progress.
REQ-012 configured_o  output  1  last configuration passed checksum.
REQ-013 error_o  output  1  last configuration failed.
REQ-014 FrameData_o  output  FrameBitsPerRow*NumRows  frame data to fabric.
REQ-015 FrameStrobe_o  output  MaxFramesPerCol*NumColumns  one-hot frame write strobe.

Function
REQ-016 Beats SHALL be packed MSB-first into 32-bit words; a word is complete after 32/DATA_W accepted beats.
REQ-017 Stream format: sync word 0xFAB0_FAB1; header word (bits [15:0] = frame count N); N records of one address word (bits [15:8] column, [7:0] frame index) plus W = NumRows*FrameBitsPerRow/32 data words; one trailer word.
REQ-018 States: IDLE, HEADER, ADDR, DATA, STROBE, CHECK, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR: discard words until one equals the sync word, then go to HEADER; all other words are ignored.
REQ-020 HEADER -> ADDR if N>0, else -> CHECK.
REQ-021 ADDR: column >= NumColumns or frame >= MaxFramesPerCol -> ERROR; otherwise -> DATA.
REQ-022 DATA: words shift into FrameData_o, first word landing in the most significant 32 bits; after W words -> STROBE.
REQ-023 STROBE lasts exactly one cycle; FrameStrobe_o bit (column*MaxFramesPerCol + frame) is high that cycle; all other bits stay low; FrameData_o is held stable that cycle and the following one.
REQ-024 After STROBE: -> ADDR if records remain, else -> CHECK.
REQ-025 Checksum = modulo-2^32 sum of all words from the header up to, but excluding, the trailer; CHECK compares the trailer to it -> DONE on match, ERROR on mismatch.
REQ-026 bitstream_ready_o SHALL be low in STROBE and during the cycle the trailer is evaluated; it SHALL be high in all other states.
REQ-027 busy_o is high in HEADER, ADDR, DATA, STROBE, CHECK and low otherwise.
REQ-028 configured_o is set on entry to DONE; error_o is set on entry to ERROR; both clear on sync detection.
REQ-029 A sync word received mid-configuration is treated as data, with no resynchronisation.
REQ-030 Partial beats held in the packer at sync detection SHALL be discarded only at reset.

Reset
REQ-031 During reset: state IDLE; packer and counters cleared; all outputs 0; bitstream_ready_o 0.
REQ-032 Reset asserted mid-configuration SHALL abort immediately with no strobe emitted.

Structure
REQ-033 Package fabric_config_pkg holds the state enum, SYNC_WORD, and the address-field bit positions.
REQ-034 Sub-module fabric_config_packer implements DATA_W-to-32 packing with valid/ready.

Verification
REQ-035 DATA_W=32, N=1, column 2, frame 5, W words 0x1..0xE, correct trailer -> one-cycle FrameStrobe_o[45]; FrameData_o[447:416]=0x1; then configured_o=1 and busy_o=0.
REQ-036 Same stream with DATA_W=8 and random valid gaps -> identical strobe and data; bitstream_ready_o low during STROBE.
REQ-037 Trailer off by 1 -> error_o=1, configured_o=0, busy_o=0.
REQ-038 Column 9 -> ERROR; no strobe is ever asserted.
REQ-039 N=0 with trailer 0x0000_0000 -> DONE, no strobes; a second sync then clears configured_o.
REQ-040 rst_ni pulsed low during DATA -> all outputs 0; a fresh, valid stream afterwards configures correctly.

Source files
------------

// File: rtl/fabric_config_pkg.sv
// Shared types and constants for the fabric frame loader: FSM state encoding,
// the stream sync word and the bit positions of the header/address fields.
package fabric_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ADDR,
    ST_DATA,
    ST_STROBE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam int COL_MSB = 15;
  localparam int COL_LSB = 8;
  localparam int FRM_MSB = 7;
  localparam int FRM_LSB = 0;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;

endpackage

// File: rtl/fabric_config_packer.sv
// Packs DATA_W-bit bitstream beats MSB-first into 32-bit words. The completed
// word is presented combinationally in the cycle its final beat is accepted.
module fabric_config_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] beat_i,
  input  logic              beat_valid_i,
  input  logic              beat_ready_i,
  output logic [31:0]       word_o,
  output logic              word_valid_o
);

  localparam int BEATS = 32 / DATA_W;

  logic accept;
  assign accept = beat_valid_i & beat_ready_i;

  generate
    if (BEATS == 1) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign word_o         = beat_i;
      assign word_valid_o   = accept;
    end else begin : g_pack
      localparam int            CW   = $clog2(BEATS);
      localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

      logic [31-DATA_W:0] part_q;
      logic [CW-1:0]      cnt_q;
      logic [31:0]        joined;

      // Earlier beats already sit in the upper bits; the new beat fills the bottom.
      assign joined       = {part_q, beat_i};
      assign word_o       = joined;
      assign word_valid_o = accept && (cnt_q == LAST);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          part_q <= '0;
          cnt_q  <= '0;
        end else if (accept) begin
          part_q <= joined[31-DATA_W:0];
          cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fabric_frame_loader.sv
// Parses a framed configuration bitstream, shifts frame data out to the fabric,
// pulses a one-hot frame strobe per record and verifies a trailing checksum.
module fabric_frame_loader
  import fabric_config_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 9,
  parameter int NumRows         = 14,
  parameter int DATA_W          = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [DATA_W-1:0]                   bitstream_data_i,
  input  logic                                bitstream_valid_i,
  output logic                                bitstream_ready_o,
  output logic                                busy_o,
  output logic                                configured_o,
  output logic                                error_o,
  output logic [FrameBitsPerRow*NumRows-1:0]  FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o
);

  localparam int              W      = NumRows * FrameBitsPerRow / 32;
  localparam int              FW     = FrameBitsPerRow * NumRows;
  localparam int              NS     = MaxFramesPerCol * NumColumns;
  localparam logic [15:0]     W_LAST = 16'(W - 1);
  localparam logic [31:0]     NCOL   = 32'(NumColumns);
  localparam logic [31:0]     NFRM   = 32'(MaxFramesPerCol);
  localparam logic [NS-1:0]   ONE    = NS'(1);

  state_e          state_q, state_d;
  logic [15:0]     rec_q, rec_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [7:0]      col_q, col_d;
  logic [7:0]      frm_q, frm_d;
  logic [31:0]     sum_q, sum_d;
  logic [31:0]     trl_q, trl_d;
  logic            trl_got_q, trl_got_d;
  logic [FW-1:0]   data_q, data_d;
  logic [NS-1:0]   strobe_q, strobe_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            cfg_q, cfg_d;
  logic            err_q, err_d;

  logic [31:0]     word;
  logic            word_valid;
  logic [FW+31:0]  data_shift;
  logic [31:0]     col_w, frm_w;
  logic [31:0]     strobe_idx;

  fabric_config_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .beat_i      (bitstream_data_i),
    .beat_valid_i(bitstream_valid_i),
    .beat_ready_i(ready_q),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  assign data_shift = {data_q, word};
  assign col_w      = {24'b0, word[COL_MSB:COL_LSB]};
  assign frm_w      = {24'b0, word[FRM_MSB:FRM_LSB]};
  assign strobe_idx = 32'(col_q) * NFRM + 32'(frm_q);

  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    wcnt_d    = wcnt_q;
    col_d     = col_q;
    frm_d     = frm_q;
    sum_d     = sum_q;
    trl_d     = trl_q;
    trl_got_d = trl_got_q;
    data_d    = data_q;
    cfg_d     = cfg_q;
    err_d     = err_q;
    strobe_d  = '0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (word_valid && word == SYNC_WORD) begin
          state_d = ST_HEADER;
          sum_d   = '0;
          cfg_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_HEADER: begin
        if (word_valid) begin
          sum_d     = sum_q + word;
          rec_d     = word[CNT_MSB:CNT_LSB];
          trl_got_d = 1'b0;
          state_d   = (word[CNT_MSB:CNT_LSB] != '0) ? ST_ADDR : ST_CHECK;
        end
      end
      ST_ADDR: begin
        if (word_valid) begin
          sum_d  = sum_q + word;
          col_d  = word[COL_MSB:COL_LSB];
          frm_d  = word[FRM_MSB:FRM_LSB];
          wcnt_d = '0;
          if (col_w >= NCOL || frm_w >= NFRM) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          sum_d  = sum_q + word;
          data_d = data_shift[FW-1:0];
          if (wcnt_q == W_LAST) begin
            state_d  = ST_STROBE;
            rec_d    = rec_q - 1'b1;
            strobe_d = ONE << strobe_idx;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_STROBE: begin
        trl_got_d = 1'b0;
        state_d   = (rec_q != '0) ? ST_ADDR : ST_CHECK;
      end
      ST_CHECK: begin
        // First capture the trailer, then compare it in a cycle with input stalled.
        if (!trl_got_q) begin
          if (word_valid) begin
            trl_d     = word;
            trl_got_d = 1'b1;
          end
        end else if (trl_q == sum_q) begin
          state_d = ST_DONE;
          cfg_d   = 1'b1;
        end else begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_STROBE) && !(state_d == ST_CHECK && trl_got_d);
    busy_d  = (state_d == ST_HEADER) || (state_d == ST_ADDR) || (state_d == ST_DATA) ||
              (state_d == ST_STROBE) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      wcnt_q    <= '0;
      col_q     <= '0;
      frm_q     <= '0;
      sum_q     <= '0;
      trl_q     <= '0;
      trl_got_q <= 1'b0;
      data_q    <= '0;
      strobe_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      cfg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      wcnt_q    <= wcnt_d;
      col_q     <= col_d;
      frm_q     <= frm_d;
      sum_q     <= sum_d;
      trl_q     <= trl_d;
      trl_got_q <= trl_got_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      cfg_q     <= cfg_d;
      err_q     <= err_d;
    end
  end

  assign bitstream_ready_o = ready_q;
  assign busy_o            = busy_q;
  assign configured_o      = cfg_q;
  assign error_o           = err_q;
  assign FrameData_o       = data_q;
  assign FrameStrobe_o     = strobe_q;

endmodule
